// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router source-side transmitter:
//   tx_state_e    transmitter FSM states
//   LEN_W/ADDR_W  widths of the header length and address fields
//   ADDR_INVALID  the one destination code the router has no port for
//   pack_hdr()    builds the router header byte {len, addr}
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PAY,
    PAR,
    EWAIT
  } tx_state_e;

  function automatic logic [LEN_W+ADDR_W-1:0] pack_hdr(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_src_buf.sv
// -----------------------------------------------------------------------------
// router_src_buf
// Payload store for one packet: a 2**PTR_W x DATA_W register array with a
// single write port and a single combinational read port. Both pointers
// advance by one per enabled access and return to zero on clr. The array
// contents are never cleared; only the pointers are.
//
// Ports:
//   clock    system clock
//   clr      synchronous pointer clear (start of a new packet / reset)
//   wr_en    write wr_data at wr_ptr, then advance wr_ptr
//   wr_data  byte to store
//   rd_en    advance rd_ptr (rd_data is the byte at the current rd_ptr)
//   rd_data  byte at rd_ptr
//   wr_ptr   number of bytes written since clr
//   rd_ptr   number of bytes read since clr
// -----------------------------------------------------------------------------
module router_src_buf
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PTR_W  = LEN_W
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr
);

  localparam int DEPTH = 1 << PTR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_src_tx.sv
// -----------------------------------------------------------------------------
// router_src_tx
// Source-side packet transmitter for the 1x3 router. A request (address,
// length, corrupt flag) is accepted, the whole payload is buffered, then the
// packet is driven into the router input port as header, payload bytes and a
// trailing parity byte, honouring the router's busy stall. After the parity
// byte is taken the router error output is watched for ERR_WIN cycles and a
// one-cycle done pulse reports the packet outcome. Requests to address 3 are
// rejected without touching payload or router.
//
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_addr/req_len       destination port (0..2) and payload length
//   req_corrupt            send inverted parity
//   pl_valid/pl_ready      payload byte handshake, pl_data carries the byte
//   d_in, pkt_valid        registered router input port
//   busy                   router stall (ignored outside HDR/PAY/PAR)
//   error                  router parity error (sampled only in EWAIT)
//   done                   one-cycle completion pulse
//   done_err               with done: router error seen in the window
//   bad_addr               with done: request rejected for address 3
// -----------------------------------------------------------------------------
module router_src_tx
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 63,
  parameter int ERR_WIN = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_corrupt,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  output logic [DATA_W-1:0] d_in,
  output logic              pkt_valid,
  input  logic              busy,
  input  logic              error,
  output logic              done,
  output logic              done_err,
  output logic              bad_addr
);

  localparam int         PTR_W   = $clog2(MAX_LEN + 1);
  localparam logic [2:0] EW_LAST = 3'(ERR_WIN - 1);

  tx_state_e state, state_nxt;

  // Latched request
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              corrupt_q;

  // Router-side output register and its valid
  logic [DATA_W-1:0] d_p0, d_nxt;
  logic              vld_p0, vld_nxt;

  logic [DATA_W-1:0] parity_q;
  logic [DATA_W-1:0] par_byte;
  logic [2:0]        ecnt;
  logic              err_flag;
  logic              bad_pend;

  logic              req_hs;
  logic              pl_hs;
  logic              load_done;
  logic              ew_last;

  logic              buf_clr;
  logic              buf_rd_en;
  logic [DATA_W-1:0] buf_rd_data;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Handshakes and status outputs; reset forces every output quiet at once
  assign req_ready = (state == IDLE) && !reset;
  assign pl_ready  = (state == LOAD) && (len_q != '0) && !reset;
  assign req_hs    = req_valid && req_ready;
  assign pl_hs     = pl_valid && pl_ready;

  // Last byte of the payload lands this edge, or there is no payload at all
  assign load_done = (state == LOAD) &&
                     ((len_q == '0) || (pl_hs && (wr_ptr == len_q - 1'b1)));

  assign ew_last  = (state == EWAIT) && (ecnt == EW_LAST);
  assign done     = !reset && (bad_pend || ew_last);
  assign done_err = !reset && ew_last && (err_flag || error);
  assign bad_addr = !reset && bad_pend;

  assign par_byte = corrupt_q ? ~parity_q : parity_q;

  assign d_in      = d_p0;
  assign pkt_valid = vld_p0;

  // New packets restart the buffer from slot 0
  assign buf_clr = reset || req_hs;

  router_src_buf #(
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clock   (clock),
    .clr     (buf_clr),
    .wr_en   (pl_hs),
    .wr_data (pl_data),
    .rd_en   (buf_rd_en),
    .rd_data (buf_rd_data),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // HDR and PAY share one rule: once rd_ptr has caught up with len every
  // payload byte has been handed to the router, so the parity byte follows.
  always_comb begin
    state_nxt = state;
    d_nxt     = d_p0;
    vld_nxt   = vld_p0;
    buf_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (req_hs && (req_addr != ADDR_INVALID)) state_nxt = LOAD;
      end
      LOAD: begin
        if (load_done) begin
          state_nxt = HDR;
          d_nxt     = pack_hdr(len_q, addr_q);
          vld_nxt   = 1'b1;
        end
      end
      HDR, PAY: begin
        if (!busy) begin
          if (rd_ptr == len_q) begin
            state_nxt = PAR;
            d_nxt     = par_byte;
            vld_nxt   = 1'b0;
          end else begin
            state_nxt = PAY;
            d_nxt     = buf_rd_data;
            vld_nxt   = 1'b1;
            buf_rd_en = 1'b1;
          end
        end
      end
      PAR: begin
        if (!busy) begin
          state_nxt = EWAIT;
          d_nxt     = '0;
          vld_nxt   = 1'b0;
        end
      end
      EWAIT: begin
        if (ecnt == EW_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: router port register, parity accumulator, error window
  always_ff @(posedge clock) begin
    if (reset) begin
      d_p0     <= '0;
      vld_p0   <= 1'b0;
      parity_q <= '0;
      ecnt     <= '0;
      err_flag <= 1'b0;
      bad_pend <= 1'b0;
    end else begin
      d_p0     <= d_nxt;
      vld_p0   <= vld_nxt;
      bad_pend <= req_hs && (req_addr == ADDR_INVALID);
      if (req_hs)     parity_q <= pack_hdr(req_len, req_addr);
      else if (pl_hs) parity_q <= parity_q ^ pl_data;
      if (state == PAR) begin
        ecnt     <= '0;
        err_flag <= 1'b0;
      end else if (state == EWAIT) begin
        ecnt     <= ecnt + 1'b1;
        err_flag <= err_flag || error;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (req_hs) begin
      addr_q    <= req_addr;
      len_q     <= req_len;
      corrupt_q <= req_corrupt;
    end
  end

endmodule

// File: tb/tb_router_src_tx.sv
// -----------------------------------------------------------------------------
// tb_router_src_tx
// Bench for router_src_tx. Directed packets from the bring-up plan followed by
// randomized packets. A router-side monitor collects every byte the router
// would take, which is compared with the byte list a packet should produce:
// header {len,addr}, the payload, then the XOR of all of them (inverted when
// corrupt). Completion timing and status are checked per packet.
// -----------------------------------------------------------------------------
module tb_router_src_tx;

  localparam int ERR_WIN = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_corrupt;
  logic       pl_valid, pl_ready;
  logic [7:0] pl_data;
  logic [7:0] d_in;
  logic       pkt_valid;
  logic       busy, error;
  logic       done, done_err, bad_addr;

  always #5 clock = ~clock;

  router_src_tx #(.DATA_W(8), .MAX_LEN(63), .ERR_WIN(ERR_WIN)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_corrupt (req_corrupt),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .pl_data     (pl_data),
    .d_in        (d_in),
    .pkt_valid   (pkt_valid),
    .busy        (busy),
    .error       (error),
    .done        (done),
    .done_err    (done_err),
    .bad_addr    (bad_addr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Shared bench state
  int         cyc       = 0;
  logic [7:0] pl_mem [64];
  logic [7:0] got_q [$];
  bit         in_pkt    = 0;
  bit         take_seen = 0;
  bit         par_flag  = 0;
  bit         hold_arm  = 0;
  logic [7:0] hold_d;
  logic       hold_v;
  int         first_pv_cyc   = 0;
  int         first_take_cyc = 0;
  int         par_cyc        = 0;
  int         busy_pct  = 0;
  int         busy_hold = 0;
  int         err_at    = 0;
  int         ew_k      = 0;
  bit         noise     = 0;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  // Router-side monitor: a byte is taken when busy is low at the next edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        in_pkt   = 0;
        hold_arm = 0;
      end else begin
        if (hold_arm) begin
          chk("hold_d", d_in, hold_d);
          chk("hold_v", pkt_valid, hold_v);
        end
        hold_arm = 0;
        if (pkt_valid && !in_pkt) begin
          in_pkt       = 1;
          first_pv_cyc = cyc;
        end
        if (in_pkt) begin
          if (busy) begin
            hold_arm = 1;
            hold_d   = d_in;
            hold_v   = pkt_valid;
          end else begin
            got_q.push_back(d_in);
            if (!take_seen) begin
              take_seen      = 1;
              first_take_cyc = cyc;
            end
            if (!pkt_valid) begin
              in_pkt   = 0;
              par_cyc  = cyc;
              par_flag = 1;
            end
          end
        end
      end
    end
  end

  // Router stall generator
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (busy_hold > 0) begin
        busy = 1'b1;
        busy_hold--;
      end else begin
        busy = (busy_pct > 0) && ($urandom_range(0, 99) < busy_pct);
      end
    end
  end

  // Router error generator: ew_k counts cycles after parity acceptance.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (par_flag) begin
        par_flag = 0;
        ew_k     = 1;
      end else if (ew_k != 0) begin
        ew_k = (ew_k >= 8) ? 0 : ew_k + 1;
      end
      error = ((ew_k != 0) && (ew_k == err_at)) ||
              (noise && in_pkt && ($urandom_range(0, 3) == 0));
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: bench did not finish, %0d checks passed", n_pass);
    $fatal(1, "watchdog");
  end

  // Entered and left at posedge+1.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] n, input logic c,
                         input int gap, input bit tog, input int ea,
                         input bit hold2, input bit do_rst);
    logic [7:0] exp_q [$];
    logic [7:0] p;
    int         i, t, req_cyc, last_pl_cyc, dn;
    bit         ok;
    p = 8'((int'(n) * 4) + int'(a));
    exp_q.push_back(p);
    for (int k = 0; k < int'(n); k++) begin
      exp_q.push_back(pl_mem[k]);
      p = p ^ pl_mem[k];
    end
    if (c) p = ~p;
    exp_q.push_back(p);
    got_q.delete();
    take_seen = 0;
    err_at    = ea;

    req_valid = 1'b1; req_addr = a; req_len = n; req_corrupt = c;
    ok = 0; req_cyc = 0; t = 0;
    while (!ok && t < 50) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; req_cyc = cyc; end
      @(posedge clock); #1; t++;
    end
    req_valid = 1'b0;
    chk("req_accept", ok, 1);
    if (!ok) return;

    if (a == 2'd3) begin
      @(negedge clock);
      chk("bad_done", done, 1);
      chk("bad_flag", bad_addr, 1);
      chk("bad_pl_ready", pl_ready, 0);
      chk("bad_pkt_valid", pkt_valid, 0);
      @(negedge clock);
      chk("bad_done_pulse", done, 0);
      @(posedge clock); #1;
      return;
    end

    last_pl_cyc = req_cyc; i = 0; t = 0;
    while (i < int'(n) && t < 1000) begin
      pl_valid = tog ? ((t % 2) == 0) : ($urandom_range(0, 99) >= gap);
      pl_data  = pl_mem[i];
      @(negedge clock);
      if (pl_valid && pl_ready) begin
        i++;
        last_pl_cyc = cyc;
        if (i == int'(n) && hold2) busy_hold = 2;
      end
      @(posedge clock); #1; t++;
    end
    pl_valid = 1'b0;
    chk("pl_count", i, n);

    if (do_rst) begin
      t = 0;
      while (got_q.size() < 10 && t < 500) begin
        @(negedge clock); t++;
      end
      chk("rst_reach", got_q.size() >= 10, 1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_pkt_valid", pkt_valid, 0);
      chk("rst_d_in", d_in, 0);
      dn = 0;
      repeat (80) begin
        @(negedge clock);
        if (done) dn++;
      end
      chk("rst_no_done", dn, 0);
      @(posedge clock); #1;
      return;
    end

    ok = 0; t = 0;
    while (!ok && t < 1000) begin
      @(negedge clock);
      if (done) ok = 1;
      t++;
    end
    chk("done_seen", ok, 1);
    if (ok) begin
      chk("done_err", done_err, (ea >= 1) && (ea <= ERR_WIN));
      chk("done_bad_addr", bad_addr, 0);
      chk("done_time", cyc - par_cyc, ERR_WIN);
      chk("nbytes", got_q.size(), int'(n) + 2);
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        chk($sformatf("byte%0d", k), got_q[k], exp_q[k]);
      if (n == 0) chk("hdr_latency", first_pv_cyc - req_cyc, 2);
      else        chk("hdr_latency", first_pv_cyc - last_pl_cyc, 1);
      if (busy_pct == 0 && !hold2) chk("wire_time", par_cyc - first_pv_cyc, int'(n) + 1);
      if (hold2) chk("hdr_hold", first_take_cyc - first_pv_cyc, 2);
      @(negedge clock);
      chk("done_pulse", done, 0);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [1:0] ra;
    logic [5:0] rn;
    int         sel;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_corrupt = 1'b0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; error = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_d_in0", d_in, 0);
    chk("rst_pkt_valid0", pkt_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_bad_addr", bad_addr, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", req_ready, 1);
    @(posedge clock); #1;

    // Basic packet, then same packet with header stalled two cycles
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 1'b0, 0, 0, 0, 0, 0);
    run_pkt(2'd1, 6'd3, 1'b0, 0, 0, 0, 1, 0);
    // Empty payload
    run_pkt(2'd2, 6'd0, 1'b0, 0, 0, 0, 0, 0);
    // Corrupted parity with router error in the window
    pl_mem[0] = 8'h5A;
    run_pkt(2'd0, 6'd1, 1'b1, 0, 0, 2, 0, 0);
    // Illegal address, then a legal request straight after
    run_pkt(2'd3, 6'd5, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) pl_mem[k] = 8'($urandom);
    run_pkt(2'd0, 6'd4, 1'b0, 0, 0, 0, 0, 0);
    // Full-length packet aborted by reset, then a clean packet
    run_pkt(2'd2, 6'd63, 1'b0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 64; k++) pl_mem[k] = 8'($urandom);
    run_pkt(2'd1, 6'd5, 1'b0, 0, 0, 0, 0, 0);

    // Randomized packets with stalls, payload gaps and error noise
    noise = 1;
    for (int r = 0; r < 24; r++) begin
      ra  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      rn  = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63 : 6'($urandom_range(1, 20));
      for (int k = 0; k < 64; k++) pl_mem[k] = 8'($urandom);
      busy_pct = (r % 3) * 30;
      run_pkt(ra, rn, 1'($urandom_range(0, 1)), $urandom_range(0, 1) * 40, 0,
              $urandom_range(0, ERR_WIN + 1), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
